// File: rtl/ro_trng_ctrl.sv
// ro_trng_ctrl: ring-oscillator TRNG controller with settle/cool-down duty cycling and a repetition-count health test.
// Define RO_TRNG_VN_DEBIAS_EN to enable von Neumann debiasing of raw bit pairs.
module ro_trng_ctrl #(
  parameter int N_RO      = 16,
  parameter int WIDTH     = 8,
  parameter int SETTLE    = 4,
  parameter int MAX_ON    = 256,
  parameter int REP_LIMIT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_RO-1:0]  ro_bits,
  output logic             ro_en,
  output logic [WIDTH-1:0] d_out,
  output logic             d_valid,
  input  logic             d_ready,
  output logic             health_fail
);
  localparam int TW = $clog2(SETTLE);
  localparam int OW = $clog2(MAX_ON);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(REP_LIMIT + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_COLLECT, S_COOL, S_HOLD, S_FAIL} state_t;

  state_t           state_q, state_d;
  logic [N_RO-1:0]  s1_q, s2_q;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [OW-1:0]    on_q, on_d;
  logic [WIDTH-1:0] word_q, word_d, d_out_q, d_out_d, shifted;
  logic [BW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    rep_q, rep_d, rep_nx;
  logic             last_q, last_d, ro_en_q, ro_en_d, d_valid_q, d_valid_d, fail_q, fail_d;
  logic             raw, acc_v, acc_b, done;

  assign raw     = ^s2_q;
  assign shifted = WIDTH'({word_q, acc_b});
  assign done    = acc_v && (cnt_q == BW'(WIDTH - 1));
  assign rep_nx  = (rep_q != '0 && raw == last_q) ? ((rep_q == RW'(REP_LIMIT)) ? rep_q : rep_q + 1'b1) : RW'(1);
  assign ro_en_d = (state_d == S_SETTLE) || (state_d == S_COLLECT);

`ifdef RO_TRNG_VN_DEBIAS_EN
  logic pv_q, pv_d, pb_q, pb_d;
  // 01 -> 0, 10 -> 1: the emitted bit is the first bit of an unequal pair
  assign acc_v = pv_q && (pb_q != raw);
  assign acc_b = pb_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pv_q <= 1'b0;
      pb_q <= 1'b0;
    end else begin
      pv_q <= pv_d;
      pb_q <= pb_d;
    end
`else
  assign acc_v = 1'b1;
  assign acc_b = raw;
`endif

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    on_d      = on_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
    rep_d     = rep_q;
    last_d    = last_q;
    d_out_d   = d_out_q;
    d_valid_d = d_valid_q;
    fail_d    = fail_q;
`ifdef RO_TRNG_VN_DEBIAS_EN
    pv_d      = pv_q;
    pb_d      = pb_q;
`endif
    case (state_q)
      S_IDLE: if (en) begin
        state_d = S_SETTLE;
        tmr_d   = '0;
        word_d  = '0;
        cnt_d   = '0;
      end
      S_SETTLE: if (!en) state_d = S_IDLE;
      else if (tmr_q == TW'(SETTLE - 1)) begin
        state_d = S_COLLECT;
        on_d    = '0;
        rep_d   = '0;
`ifdef RO_TRNG_VN_DEBIAS_EN
        pv_d    = 1'b0;
`endif
      end else tmr_d = tmr_q + 1'b1;
      S_COLLECT: if (!en) state_d = S_IDLE;
      else begin
        rep_d  = rep_nx;
        last_d = raw;
        on_d   = on_q + 1'b1;
`ifdef RO_TRNG_VN_DEBIAS_EN
        pv_d   = ~pv_q;
        pb_d   = raw;
`endif
        if (rep_nx == RW'(REP_LIMIT)) begin
          state_d   = S_FAIL;
          fail_d    = 1'b1;
          d_valid_d = 1'b0;
        end else begin
          if (acc_v) begin
            word_d = shifted;
            cnt_d  = done ? '0 : cnt_q + 1'b1;
          end
          if (done) begin
            state_d   = S_HOLD;
            d_out_d   = shifted;
            d_valid_d = 1'b1;
          end else if (on_q == OW'(MAX_ON - 1)) begin
            // partial word and bit count survive the cool-down
            state_d = S_COOL;
            tmr_d   = '0;
          end
        end
      end
      S_COOL: if (!en) state_d = S_IDLE;
      else if (tmr_q == TW'(SETTLE - 1)) begin
        state_d = S_SETTLE;
        tmr_d   = '0;
      end else tmr_d = tmr_q + 1'b1;
      S_HOLD: if (d_valid_q && d_ready) begin
        d_valid_d = 1'b0;
        state_d   = en ? S_SETTLE : S_IDLE;
        tmr_d     = '0;
      end
      S_FAIL: state_d = S_FAIL;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= S_IDLE;
      s1_q      <= '0;
      s2_q      <= '0;
      tmr_q     <= '0;
      on_q      <= '0;
      word_q    <= '0;
      cnt_q     <= '0;
      rep_q     <= '0;
      last_q    <= 1'b0;
      ro_en_q   <= 1'b0;
      d_out_q   <= '0;
      d_valid_q <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= ro_bits;
      s2_q      <= s1_q;
      tmr_q     <= tmr_d;
      on_q      <= on_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      rep_q     <= rep_d;
      last_q    <= last_d;
      ro_en_q   <= ro_en_d;
      d_out_q   <= d_out_d;
      d_valid_q <= d_valid_d;
      fail_q    <= fail_d;
    end

  assign ro_en       = ro_en_q;
  assign d_out       = d_out_q;
  assign d_valid     = d_valid_q;
  assign health_fail = fail_q;
endmodule

// File: tb/tb_ro_trng_ctrl.sv
// tb_ro_trng_ctrl: directed table-driven bench for ro_trng_ctrl (either RO_TRNG_VN_DEBIAS_EN build).
module tb_ro_trng_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       d_ready = 1'b0;
  logic [1:0] ro_bits = 2'b00;
  logic       ro_en, d_valid, health_fail;
  logic [3:0] d_out;
  logic       h_ro_en, h_d_valid, h_fail;
  logic [7:0] h_d_out;
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ro_trng_ctrl #(.N_RO(2), .WIDTH(4), .SETTLE(2), .MAX_ON(16), .REP_LIMIT(6)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ro_bits(ro_bits), .ro_en(ro_en),
    .d_out(d_out), .d_valid(d_valid), .d_ready(d_ready), .health_fail(health_fail));

  ro_trng_ctrl #(.N_RO(2), .WIDTH(8), .SETTLE(2), .MAX_ON(16), .REP_LIMIT(6)) u_h (
    .clk(clk), .rst_n(rst_n), .en(en), .ro_bits(ro_bits), .ro_en(h_ro_en),
    .d_out(h_d_out), .d_valid(h_d_valid), .d_ready(d_ready), .health_fail(h_fail));

  typedef struct {
    logic [15:0] raw;
    int          nraw;
    logic [3:0]  exp;
  } vec_t;

  vec_t tv[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called just after the edge that entered SETTLE; raw[i] is the i-th raw bit seen in COLLECT.
  task automatic run_vec(input logic [15:0] raw, input int nraw, input logic [3:0] exp, input string nm);
    chk({nm, " settle ro_en"}, ro_en, 1);
    for (int i = 0; i < nraw; i++) begin
      ro_bits = {1'b0, raw[i]};
      tick;
    end
    tick;
    chk({nm, " early valid"}, d_valid, 0);
    tick;
    chk({nm, " valid"}, d_valid, 1);
    chk({nm, " d_out"}, d_out, exp);
    chk({nm, " hold ro_en"}, ro_en, 0);
    tick;
    chk({nm, " held valid"}, d_valid, 1);
    chk({nm, " held d_out"}, d_out, exp);
    d_ready = 1'b1;
    tick;
    d_ready = 1'b0;
    chk({nm, " consumed"}, d_valid, 0);
    chk({nm, " resettle ro_en"}, ro_en, 1);
  endtask

  initial begin
    logic [15:0] p_raw, f_raw;
    int          p_n, f_n;
`ifdef RO_TRNG_VN_DEBIAS_EN
    logic [25:0] seq;
    tv[0] = '{16'h051E, 12, 4'h7};
    tv[1] = '{16'h00A5, 8, 4'hC};
    tv[2] = '{16'h0678, 12, 4'h5};
    tv[3] = '{16'h006A, 8, 4'h1};
    p_raw = 16'h0005; p_n = 4;
    f_raw = 16'h00A6; f_n = 8;
`else
    tv[0] = '{16'h000D, 4, 4'hB};
    tv[1] = '{16'h0008, 4, 4'h1};
    tv[2] = '{16'h0007, 4, 4'hE};
    tv[3] = '{16'h000A, 4, 4'h5};
    p_raw = 16'h0003; p_n = 2;
    f_raw = 16'h0002; f_n = 4;
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("rst ro_en", ro_en, 0);
    chk("rst d_valid", d_valid, 0);
    chk("rst d_out", d_out, 0);
    chk("rst health", health_fail, 0);
    en = 1'b1;
    tick;
    chk("rst hold ro_en", ro_en, 0);
    rst_n = 1'b1;
    tick;
    for (int v = 0; v < 4; v++) run_vec(tv[v].raw, tv[v].nraw, tv[v].exp, $sformatf("vec%0d", v));

    // abort after two accepted bits, then a fresh word must need all four bits
    for (int i = 0; i < p_n; i++) begin
      ro_bits = {1'b0, p_raw[i]};
      tick;
    end
    tick;
    tick;
    en = 1'b0;
    tick;
    chk("abort ro_en", ro_en, 0);
    chk("abort d_valid", d_valid, 0);
    en = 1'b1;
    tick;
    run_vec(f_raw, f_n, 4'h4, "fresh");

`ifdef RO_TRNG_VN_DEBIAS_EN
    // pairs 10,10 then only discarded pairs until MAX_ON, then 01,01 after the cool-down
    seq = '0;
    seq[0] = 1'b1;
    seq[2] = 1'b1;
    for (int k = 4; k < 20; k++) seq[k] = ((k - 4) % 4) >= 2;
    seq[21] = 1'b1;
    seq[23] = 1'b1;
    for (int k = 0; k < 26; k++) begin
      ro_bits = {1'b0, seq[k]};
      tick;
      if (k + 1 == 17) chk("maxon last collect ro_en", ro_en, 1);
      if (k + 1 == 18) chk("maxon cool ro_en", ro_en, 0);
      if (k + 1 == 19) chk("maxon cool2 ro_en", ro_en, 0);
      if (k + 1 == 20) chk("maxon resettle ro_en", ro_en, 1);
      if (k + 1 == 22) chk("maxon recollect ro_en", ro_en, 1);
      if (k + 1 == 25) chk("maxon early valid", d_valid, 0);
      if (k + 1 == 26) begin
        chk("maxon valid", d_valid, 1);
        chk("maxon d_out", d_out, 4'hC);
        chk("maxon health", health_fail, 0);
      end
    end
    d_ready = 1'b1;
    tick;
    d_ready = 1'b0;
    chk("maxon consumed", d_valid, 0);
`endif

    // asynchronous reset in the middle of COLLECT
    ro_bits = 2'b01;
    tick;
    tick;
    tick;
    chk("mid collect ro_en", ro_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async ro_en", ro_en, 0);
    chk("async d_valid", d_valid, 0);
    chk("async d_out", d_out, 0);
    chk("async health", health_fail, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick;
    chk("restart ro_en", h_ro_en, 1);
    for (int i = 0; i < 7; i++) tick;
    chk("pre-trip health", h_fail, 0);
    chk("pre-trip ro_en", h_ro_en, 1);
    tick;
    chk("trip health", h_fail, 1);
    chk("trip ro_en", h_ro_en, 0);
    chk("trip d_valid", h_d_valid, 0);
    d_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      en = i[0];
      ro_bits = {1'b0, i[1]};
      tick;
      chk("fail sticky", h_fail, 1);
      chk("fail ro_en", h_ro_en, 0);
      chk("fail d_valid", h_d_valid, 0);
    end
    d_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("fail cleared", h_fail, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ro_trng_ctrl.md
RO_TRNG_CTRL -- requirements
Module: ro_trng_ctrl

Interface
REQ-001 Parameter N_RO, default 16: ring-oscillator inputs, even, >=2.
REQ-002 Parameter WIDTH, default 8: output word width, 1..32.
REQ-003 Parameter SETTLE, default 4: cycles ro_en is high before sampling starts, and cool-down length; >=2.
REQ-004 Parameter MAX_ON, default 256: max COLLECT cycles per ro_en burst, >=WIDTH.
REQ-005 Parameter REP_LIMIT, default 32: consecutive identical raw bits that trip the health test, >=2.
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 en  input  1  generation request, level.
REQ-009 ro_bits  input  N_RO  raw outputs of the external ring-oscillator array, asynchronous.
REQ-010 ro_en  output  1  oscillator enable, registered.
REQ-011 d_out  output  WIDTH  random word, registered.
REQ-012 d_valid  output  1  d_out holds an unconsumed word.
REQ-013 d_ready  input  1  consumer accepts d_out.
REQ-014 health_fail  output  1  sticky repetition-count failure.

Function
REQ-015 Each ro_bits bit SHALL pass through a 2-flop synchronizer; raw bit = XOR-reduction of all synchronized bits.
REQ-016 FSM states SHALL be IDLE, SETTLE, COLLECT, COOL, HOLD, FAIL.
REQ-017 IDLE: ro_en=0; en=1 -> SETTLE.
REQ-018 SETTLE: ro_en=1 for exactly SETTLE cycles, no sampling -> COLLECT.
REQ-019 COLLECT: ro_en=1; one raw bit evaluated per cycle; accepted bits shift into the word at LSB (word <= {word[WIDTH-2:0], bit}).
REQ-020 On the WIDTH-th accepted bit the word SHALL load d_out, d_valid SHALL rise the next cycle, state -> HOLD, bit counter clears.
REQ-021 If MAX_ON COLLECT cycles elapse without a full word -> COOL: ro_en=0 for SETTLE cycles, then SETTLE; partial word and bit count SHALL be preserved.
REQ-022 HOLD: ro_en=0, d_out stable; d_valid && d_ready clears d_valid next cycle and goes to SETTLE if en=1, else IDLE.
REQ-023 en=0 in SETTLE, COLLECT or COOL SHALL go to IDLE next cycle, dropping ro_en and discarding the partial word; en=0 in HOLD SHALL NOT drop d_valid.
REQ-024 Health: counter of consecutive equal raw bits, only in COLLECT; reaching REP_LIMIT SHALL set health_fail, go FAIL, force ro_en=0, d_valid=0.
REQ-025 FAIL SHALL be left only by rst_n; en and d_ready are ignored.
REQ-026 Repetition counter SHALL restart at 1 on each COLLECT entry and saturate at REP_LIMIT.

Reset
REQ-027 rst_n low SHALL asynchronously clear: state=IDLE, ro_en=0, d_out=0, d_valid=0, health_fail=0, word, bit, MAX_ON and repetition counters, synchronizers.
REQ-028 Reset mid-operation SHALL discard everything; first ro_en rise is no earlier than 1 cycle after rst_n release with en=1.

Configuration
REQ-029 Macro RO_TRNG_VN_DEBIAS_EN defined: von Neumann debiasing on non-overlapping raw pairs in COLLECT (01->0, 10->1, 00/11 discarded); the pair register clears on COLLECT entry.
REQ-030 Macro undefined: every raw bit in COLLECT is accepted; no pair register exists.
REQ-031 The health test (REQ-024) SHALL act on raw bits in both builds.

Verification (N_RO=2, WIDTH=4, SETTLE=2, MAX_ON=16, REP_LIMIT=6)
REQ-032 rst_n=0 mid-COLLECT -> ro_en=0, d_valid=0, d_out=4'h0, health_fail=0 immediately.
REQ-033 Macro undefined, en=1, raw 1,0,1,1 in COLLECT -> d_out=4'hB, d_valid=1, ro_en=0; d_ready=1 one cycle -> d_valid=0 next cycle, ro_en=1 in SETTLE.
REQ-034 Macro defined, raw pairs 01,11,10,00,10,10 -> accepted 0,1,1,1 -> d_out=4'h7.
REQ-035 Raw held 1 for 6 COLLECT cycles -> health_fail=1, ro_en=0, d_valid=0; en toggling has no effect until rst_n.
REQ-036 Macro defined, raw 0,0,1,1 repeating -> 16 COLLECT cycles, ro_en=0 for 2 cycles, 2 SETTLE cycles, COLLECT again; health_fail stays 0.
REQ-037 en=0 after 2 accepted bits -> IDLE, ro_en=0 next cycle; next request needs 4 fresh bits.
